// File: rtl/alu16_nibble_sequencer.sv
// Nibble-serial ALU sequencer: accepts a W-bit request, walks an external 4-bit ALU slice
// over the operand nibbles LSB first (rippling carry through a register), then presents
// the assembled result until the consumer takes it.
module alu16_nibble_sequencer #(
  parameter int unsigned NUM_NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4*NUM_NIBBLES-1:0] in_a,
  input  logic [4*NUM_NIBBLES-1:0] in_b,
  input  logic [2:0]               in_op,
  input  logic                     in_cin,
  output logic [3:0]               slice_a,
  output logic [3:0]               slice_b,
  output logic [2:0]               slice_op,
  output logic                     slice_cin,
  input  logic [3:0]               slice_result,
  input  logic                     slice_cout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*NUM_NIBBLES-1:0] out_result,
  output logic                     out_cout,
  output logic                     out_zero
);

  localparam int unsigned W    = 4 * NUM_NIBBLES;
  localparam int unsigned IdxW = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [W-1:0]      a_q, b_q;
  logic [2:0]        op_q;
  logic              cin_q;
  logic [IdxW-1:0]   idx_q;
  logic              carry_q;
  logic [W-1:0]      res_q;
  logic [W-1:0]      res_d;
  logic [W-1:0]      out_result_q;
  logic              out_cout_q;
  logic              is_arith;

  // Only add/sub carry anything between nibbles or out of the top.
  assign is_arith = (op_q[2:1] == 2'b00);

  // Working result with the current slice nibble merged in.
  always_comb begin
    res_d = res_q;
    res_d[{idx_q, 2'b00} +: 4] = slice_result;
  end

  // Slice drive: active only in RUN, zero otherwise.
  always_comb begin
    slice_a   = 4'h0;
    slice_b   = 4'h0;
    slice_op  = 3'b000;
    slice_cin = 1'b0;
    if (state_q == StRun) begin
      slice_a   = a_q[{idx_q, 2'b00} +: 4];
      slice_b   = b_q[{idx_q, 2'b00} +: 4];
      // 111 is remapped so every 1xx op is a defined zero on the slice.
      slice_op  = (op_q == 3'b111) ? 3'b100 : op_q;
      slice_cin = (idx_q == '0) ? (cin_q & is_arith) : carry_q;
    end
  end

  // Sequencer FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 3'b000;
      cin_q        <= 1'b0;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      res_q        <= '0;
      out_result_q <= '0;
      out_cout_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            op_q    <= in_op;
            cin_q   <= in_cin;
            idx_q   <= '0;
            carry_q <= 1'b0;
            state_q <= StRun;
          end
        end
        StRun: begin
          res_q   <= res_d;
          carry_q <= slice_cout;
          if (idx_q == LastIdx) begin
            // Publish only complete results; earlier nibbles stay in res_q.
            out_result_q <= res_d;
            out_cout_q   <= is_arith & slice_cout;
            state_q      <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign out_result = out_result_q;
  assign out_cout   = out_cout_q;
  assign out_zero   = (out_result_q == '0);

endmodule

// File: tb/tb_alu16_nibble_sequencer.sv
// Bench for alu16_nibble_sequencer: behavioural 4-bit slice, directed vector table,
// multi-cycle corner sequences and random requests checked against a word-level model.
module tb_alu16_nibble_sequencer;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [2:0]   in_op = 3'b000;
  logic         in_cin = 1'b0;
  logic [3:0]   slice_a, slice_b, slice_result;
  logic [2:0]   slice_op;
  logic         slice_cin, slice_cout;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         out_cout, out_zero;

  int total = 0;
  int bad = 0;
  bit slice_op_bad;

  alu16_nibble_sequencer #(.NUM_NIBBLES(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_op       (in_op),
    .in_cin      (in_cin),
    .slice_a     (slice_a),
    .slice_b     (slice_b),
    .slice_op    (slice_op),
    .slice_cin   (slice_cin),
    .slice_result(slice_result),
    .slice_cout  (slice_cout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_cout    (out_cout),
    .out_zero    (out_zero)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit ALU slice.
  logic [4:0] slice_sum;
  always_comb begin
    slice_sum = 5'd0;
    case (slice_op)
      3'b000:  slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_cin};
      3'b001:  slice_sum = {1'b0, slice_a} + {1'b0, ~slice_b} + {4'b0, slice_cin};
      3'b010:  slice_sum = {1'b0, slice_a & slice_b};
      3'b011:  slice_sum = {1'b0, slice_a | slice_b};
      default: slice_sum = 5'd0;
    endcase
  end
  assign slice_result = slice_sum[3:0];
  assign slice_cout   = slice_sum[4];

  // Word-level reference: {cout, result}.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [2:0] op, input logic cin);
    case (op)
      3'b000:  return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      3'b001:  return {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
      3'b010:  return {1'b0, a & b};
      3'b011:  return {1'b0, a | b};
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a request now (just after an edge); accepting edge follows.
  task automatic start_req(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] op, input logic cin, input string name);
    in_a = a; in_b = b; in_op = op; in_cin = cin; in_valid = 1'b1;
    chk({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges from the accepting edge until out_valid, bounded.
  task automatic wait_done(input logic [2:0] op, output int n);
    n = 0;
    slice_op_bad = 1'b0;
    while (!out_valid && n < 20) begin
      if (op == 3'b111 && slice_op != 3'b100) slice_op_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         input logic cin, input logic [W-1:0] exp_r, input logic exp_c,
                         input int stall, input string name);
    int n;
    out_ready = 1'b0;
    start_req(a, b, op, cin, name);
    wait_done(op, n);
    chk({name, " latency"}, 32'(n), 32'(N));
    chk({name, " result"}, 32'(out_result), 32'(exp_r));
    chk({name, " cout"}, 32'(out_cout), 32'(exp_c));
    chk({name, " zero"}, 32'(out_zero), 32'(exp_r == '0));
    chk({name, " slice idle in done"}, {21'd0, slice_a, slice_b, slice_op, slice_cin}, 32'd0);
    if (op == 3'b111) chk({name, " slice_op remap"}, 32'(slice_op_bad), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({name, " stall hold"}, {14'd0, out_valid, out_cout, out_result},
          {14'd0, 1'b1, exp_c, exp_r});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, " back to idle"}, {30'd0, out_valid, in_ready}, 32'd1);
    chk({name, " retained"}, 32'(out_result), 32'(exp_r));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         cin;
    logic [W-1:0] exp_r;
    logic         exp_c;
    string        name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int n;
    logic [W:0] m;
    logic [W-1:0] ra, rb;
    logic [2:0] rop;
    logic rcin;

    vecs.push_back('{16'h00FF, 16'h0001, 3'b000, 1'b0, 16'h0100, 1'b0, "add 00ff+1"});
    vecs.push_back('{16'hFFFF, 16'h0001, 3'b000, 1'b0, 16'h0000, 1'b1, "add ffff+1"});
    vecs.push_back('{16'h1234, 16'h1234, 3'b001, 1'b1, 16'h0000, 1'b1, "sub 1234-1234"});
    vecs.push_back('{16'h0000, 16'h0001, 3'b001, 1'b1, 16'hFFFF, 1'b0, "sub 0-1"});
    vecs.push_back('{16'hF0F0, 16'h3C3C, 3'b010, 1'b0, 16'h3030, 1'b0, "and"});
    vecs.push_back('{16'hF0F0, 16'h3C3C, 3'b011, 1'b1, 16'hFCFC, 1'b0, "or"});
    vecs.push_back('{16'hF0F0, 16'h3C3C, 3'b111, 1'b1, 16'h0000, 1'b0, "op111"});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 3'b100, 1'b1, 16'h0000, 1'b0, "op100"});
    vecs.push_back('{16'h7FFF, 16'h0000, 3'b000, 1'b1, 16'h8000, 1'b0, "add cin"});

    // Reset state.
    @(posedge clk); #1;
    chk("reset outputs", {11'd0, in_ready, out_valid, out_cout, out_zero, out_result},
        {11'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000});
    chk("reset slice", {21'd0, slice_a, slice_b, slice_op, slice_cin}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready after reset", 32'(in_ready), 32'd1);

    foreach (vecs[i])
      run_txn(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin, vecs[i].exp_r, vecs[i].exp_c,
              0, vecs[i].name);

    // Consumer stalls while a new request is offered; it must not be taken.
    start_req(16'h1111, 16'h2222, 3'b000, 1'b0, "hold");
    wait_done(3'b000, n);
    chk("hold latency", 32'(n), 32'(N));
    in_a = 16'hAAAA; in_b = 16'h5555; in_op = 3'b011; in_cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold stable", {13'd0, out_valid, in_ready, out_cout, out_result},
          {13'd0, 1'b1, 1'b0, 1'b0, 16'h3333});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold release", {14'd0, out_valid, in_ready, out_result},
        {14'd0, 1'b0, 1'b1, 16'h3333});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("hold new accepted", 32'(in_ready), 32'd0);
    wait_done(3'b011, n);
    chk("hold new latency", 32'(n), 32'(N));
    chk("hold new result", 32'(out_result), 32'hFFFF);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of RUN at nibble index 2.
    start_req(16'h0300, 16'h0400, 3'b000, 1'b0, "abort");
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort slice nibble2", {24'd0, slice_a, slice_b}, 32'h34);
    rst_n = 1'b0;
    #1;
    chk("abort reset outputs", {11'd0, in_ready, out_valid, out_cout, out_zero, out_result},
        {11'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000});
    chk("abort reset slice", {21'd0, slice_a, slice_b, slice_op, slice_cin}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort no partial", {30'd0, out_valid, in_ready}, 32'd1);
    run_txn(16'h0001, 16'h0001, 3'b000, 1'b0, 16'h0002, 1'b0, 0, "post-reset add");

    // Random requests against the word-level model.
    for (int i = 0; i < 40; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rop  = 3'($urandom_range(0, 7));
      rcin = 1'($urandom);
      m    = model(ra, rb, rop, rcin);
      run_txn(ra, rb, rop, rcin, m[W-1:0], m[W], int'($urandom_range(0, 2)), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu16_nibble_sequencer.md
ALU16_NIBBLE_SEQUENCER -- requirements
Module: alu16_nibble_sequencer

Interface
REQ-001 SHALL have parameter NUM_NIBBLES, default 4, number of 4-bit slices per operand; data width W = 4*NUM_NIBBLES.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  request accepted when in_valid & in_ready at rising clk.
REQ-007 in_a  input  W  operand A.
REQ-008 in_b  input  W  operand B.
REQ-009 in_op  input  3  000 add, 001 sub, 010 AND, 011 OR, 1xx zero.
REQ-010 in_cin  input  1  carry into nibble 0 for add/sub; caller sets 1 for two's-complement subtract.
REQ-011 slice_a  output  4  A nibble to the 4-bit ALU slice.
REQ-012 slice_b  output  4  B nibble to the slice.
REQ-013 slice_op  output  3  opcode to the slice.
REQ-014 slice_cin  output  1  carry to the slice.
REQ-015 slice_result  input  4  slice result, combinational from slice_* outputs.
REQ-016 slice_cout  input  1  slice carry out; slice computes A+B+cin (add) or A+~B+cin (sub), 0 for other ops.
REQ-017 out_valid  output  1  result valid.
REQ-018 out_ready  input  1  consumer accepts result when out_valid & out_ready at rising clk.
REQ-019 out_result  output  W  assembled result.
REQ-020 out_cout  output  1  final carry for add/sub, else 0.
REQ-021 out_zero  output  1  1 when out_result == 0.

Function
REQ-022 SHALL implement FSM states IDLE, RUN, DONE.
REQ-023 IDLE: in_ready=1, out_valid=0; on accept, latch in_a, in_b, in_op, in_cin; nibble index=0; go RUN.
REQ-024 RUN: slice_a/slice_b = latched operand nibble [4*idx+3:4*idx]; slice_op = latched op.
REQ-025 RUN: slice_cin for idx 0 = latched in_cin if op is 000/001, else 0; for idx>0 = carry captured on previous RUN edge.
REQ-026 RUN: each rising edge captures slice_result into result nibble idx, slice_cout into carry register, increments idx.
REQ-027 RUN: on edge capturing idx NUM_NIBBLES-1, go DONE; idx does not wrap past NUM_NIBBLES-1.
REQ-028 Latched op 111 SHALL drive slice_op=100 (defined zero result); ops 100-111 yield out_result 0, out_cout 0.
REQ-029 Latency uniform for all ops: out_valid rises exactly NUM_NIBBLES rising edges after the accepting edge.
REQ-030 DONE: out_valid=1, in_ready=0; out_result/out_cout/out_zero held stable until out_ready.
REQ-031 DONE with out_ready=1: go IDLE on that edge; no request accepted in same cycle (in_ready=0 in DONE).
REQ-032 in_ready=0 in RUN and DONE; in_valid and input changes there SHALL be ignored.
REQ-033 out_cout = final carry register when op 000/001, else 0.
REQ-034 out_zero SHALL be derived from the registered out_result.
REQ-035 slice_a, slice_b, slice_op, slice_cin SHALL be 0 in IDLE and DONE.
REQ-036 out_result, out_cout, out_zero SHALL retain the last result after returning to IDLE until the next completion.

Reset
REQ-037 rst_n low SHALL immediately force IDLE, idx 0, carry 0, out_result 0, out_cout 0, out_zero 1, out_valid 0, slice_* 0.
REQ-038 Reset mid-RUN or mid-DONE SHALL abort the operation with no partial result presented.
REQ-039 in_ready SHALL be 1 on first rising edge after rst_n deasserts.

Verification
REQ-040 Add 0x00FF+0x0001, cin 0 -> out_result 0x0100, cout 0, zero 0, out_valid exactly 4 edges after accept.
REQ-041 Add 0xFFFF+0x0001, cin 0 -> 0x0000, cout 1, zero 1; sub 0x1234-0x1234, cin 1 -> 0x0000, cout 1, zero 1; sub 0x0000-0x0001, cin 1 -> 0xFFFF, cout 0.
REQ-042 AND 0xF0F0,0x3C3C -> 0x3030; OR -> 0xFCFC; op 111 -> 0x0000, cout 0, slice_op observed 100 during RUN.
REQ-043 Hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands -> outputs stable, in_ready 0, new request not taken; out_ready=1 -> IDLE next edge, then new request accepted.
REQ-044 Assert rst_n low during RUN at idx 2 -> all outputs reset values immediately; subsequent add 0x0001+0x0001 -> 0x0002 with normal latency.
